// File: rtl/clock_pkg.sv
// clock_pkg: shared types and helpers for the digital clock.
//   mode_e       - set-mode state encoding (RUN, SET_HH, SET_MM, SET_SS)
//   BLINK_*      - field-select codes shared with the display multiplexer
//   HH_MAX/MS_MAX- packed-BCD upper limits of the hour and min/sec fields
//   bcd_inc      - packed-BCD increment with wrap to 00 and carry-out flag
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2,
    SET_SS = 2'd3
  } mode_e;

  localparam logic [1:0] BLINK_HH   = 2'b00;
  localparam logic [1:0] BLINK_MM   = 2'b01;
  localparam logic [1:0] BLINK_SS   = 2'b10;
  localparam logic [1:0] BLINK_NONE = 2'b11;

  localparam logic [7:0] HH_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  typedef struct packed {
    logic [7:0] value;
    logic       carry;
  } bcd_res_t;

  // Packed BCD orders the same as binary, so ">=" also folds any
  // out-of-range value back to 00 instead of letting it drift further.
  function automatic bcd_res_t bcd_inc(input logic [7:0] value, input logic [7:0] max);
    bcd_res_t res;
    if (value >= max) begin
      res.value = 8'h00;
      res.carry = 1'b1;
    end else if (value[3:0] >= 4'h9) begin
      res.value = {value[7:4] + 4'h1, 4'h0};
      res.carry = 1'b0;
    end else begin
      res.value = {value[7:4], value[3:0] + 4'h1};
      res.carry = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_debounce.sv
// btn_debounce: button conditioner.
//   clk, rst_n - clock, asynchronous active-low reset
//   btn_raw    - raw asynchronous button level (active-high)
//   press      - registered one-cycle pulse on an accepted 0->1 change
// The raw level is synchronized through two flops, then must differ from
// the accepted level for DEBOUNCE_CYCLES consecutive samples to be taken.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronizer, stability counter, accepted level and press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
      if (sync2_r == level_r) begin
        // Any sample matching the accepted level restarts qualification.
        cnt_r   <= {CNT_W{1'b0}};
        press_r <= 1'b0;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= {CNT_W{1'b0}};
        press_r <= sync2_r;
      end else begin
        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        press_r <= 1'b0;
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: HH:MM:SS timekeeping with button-driven time setting.
//   clk, rst_n    - clock, asynchronous active-low reset
//   tick_1hz      - one-cycle strobe per second
//   btn_mode_raw  - raw MODE button (steps RUN->SET_HH->SET_MM->SET_SS->RUN)
//   btn_inc_raw   - raw INC button (increments the selected field)
//   hh, mm, ss    - packed-BCD time, registered
//   blink_sel     - field being edited (BLINK_NONE in RUN), registered
//   setting       - high in any set state, registered
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode_raw,
  input  logic       btn_inc_raw,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [1:0] blink_sel,
  output logic       setting
);

  logic       mode_p_s;
  logic       inc_p_s;
  mode_e      state_r;
  mode_e      state_next_s;
  logic [7:0] hh_r, mm_r, ss_r;
  logic [7:0] hh_next_s, mm_next_s, ss_next_s;
  logic [1:0] blink_r, blink_next_s;
  logic       setting_r, setting_next_s;
  bcd_res_t   hh_inc_s, mm_inc_s, ss_inc_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_mode_raw), .press(mode_p_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_inc_raw), .press(inc_p_s)
  );

  assign hh_inc_s = bcd_inc(hh_r, HH_MAX);
  assign mm_inc_s = bcd_inc(mm_r, MS_MAX);
  assign ss_inc_s = bcd_inc(ss_r, MS_MAX);

  // Next state, next time and next display decode.
  always_comb begin
    state_next_s   = state_r;
    hh_next_s      = hh_r;
    mm_next_s      = mm_r;
    ss_next_s      = ss_r;
    blink_next_s   = BLINK_NONE;
    setting_next_s = 1'b0;

    case (state_r)
      RUN: begin
        // The tick is judged by the current state, so a tick coinciding
        // with the MODE press that leaves RUN still counts.
        if (tick_1hz) begin
          ss_next_s = ss_inc_s.value;
          if (ss_inc_s.carry) begin
            mm_next_s = mm_inc_s.value;
            if (mm_inc_s.carry) begin
              hh_next_s = hh_inc_s.value;
            end else begin
              hh_next_s = hh_r;
            end
          end else begin
            mm_next_s = mm_r;
          end
        end else begin
          ss_next_s = ss_r;
        end
        if (mode_p_s) begin
          state_next_s = SET_HH;
        end else begin
          state_next_s = RUN;
        end
      end
      // In set states MODE takes priority and drops a coincident INC.
      SET_HH: begin
        if (mode_p_s) begin
          state_next_s = SET_MM;
        end else if (inc_p_s) begin
          hh_next_s = hh_inc_s.value;
        end else begin
          state_next_s = SET_HH;
        end
      end
      SET_MM: begin
        if (mode_p_s) begin
          state_next_s = SET_SS;
        end else if (inc_p_s) begin
          mm_next_s = mm_inc_s.value;
        end else begin
          state_next_s = SET_MM;
        end
      end
      SET_SS: begin
        if (mode_p_s) begin
          state_next_s = RUN;
        end else if (inc_p_s) begin
          ss_next_s = ss_inc_s.value;
        end else begin
          state_next_s = SET_SS;
        end
      end
      default: begin
        state_next_s = RUN;
      end
    endcase

    case (state_next_s)
      SET_HH:  begin blink_next_s = BLINK_HH;   setting_next_s = 1'b1; end
      SET_MM:  begin blink_next_s = BLINK_MM;   setting_next_s = 1'b1; end
      SET_SS:  begin blink_next_s = BLINK_SS;   setting_next_s = 1'b1; end
      default: begin blink_next_s = BLINK_NONE; setting_next_s = 1'b0; end
    endcase
  end

  // State, time and display-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RUN;
      hh_r      <= 8'h00;
      mm_r      <= 8'h00;
      ss_r      <= 8'h00;
      blink_r   <= BLINK_NONE;
      setting_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      hh_r      <= hh_next_s;
      mm_r      <= mm_next_s;
      ss_r      <= ss_next_s;
      blink_r   <= blink_next_s;
      setting_r <= setting_next_s;
    end
  end

  assign hh        = hh_r;
  assign mm        = mm_r;
  assign ss        = ss_r;
  assign blink_sel = blink_r;
  assign setting   = setting_r;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb_clock_time_ctrl: directed self-checking bench for clock_time_ctrl,
// run with DEBOUNCE_CYCLES=4. Inputs change and outputs are sampled on
// the falling clock edge.
module tb_clock_time_ctrl;

  logic       clk;
  logic       rst_n;
  logic       tick_1hz;
  logic       btn_mode_raw;
  logic       btn_inc_raw;
  logic [7:0] hh, mm, ss;
  logic [1:0] blink_sel;
  logic       setting;

  int checks;
  int errors;

  clock_time_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_mode_raw(btn_mode_raw), .btn_inc_raw(btn_inc_raw),
    .hh(hh), .mm(mm), .ss(ss), .blink_sel(blink_sel), .setting(setting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_hh, input logic [7:0] e_mm,
                           input logic [7:0] e_ss, input logic [1:0] e_blink, input logic e_set);
    check({tag, "_hh"}, hh, e_hh);
    check({tag, "_mm"}, mm, e_mm);
    check({tag, "_ss"}, ss, e_ss);
    check({tag, "_blink"}, {6'b000000, blink_sel}, {6'b000000, e_blink});
    check({tag, "_setting"}, {7'b0000000, setting}, {7'b0000000, e_set});
  endtask

  // Hold the chosen buttons 8 cycles then release 8 cycles; optionally
  // emit nticks single-cycle ticks inside that window.
  task automatic press(input logic m, input logic i, input int nticks);
    for (int k = 0; k < 16; k++) begin
      btn_mode_raw = m & (k < 8);
      btn_inc_raw  = i & (k < 8);
      tick_1hz     = ((k % 2) == 1) && (k < 2 * nticks);
      @(negedge clk);
    end
    btn_mode_raw = 1'b0;
    btn_inc_raw  = 1'b0;
    tick_1hz     = 1'b0;
  endtask

  task automatic press_n(input logic m, input logic i, input int n);
    for (int k = 0; k < n; k++) press(m, i, 0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    tick_1hz     = 1'b0;
    btn_mode_raw = 1'b0;
    btn_inc_raw  = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 8'h00, 8'h00, 8'h00, 2'b11, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // 61 seconds of running time.
    ticks(61);
    check_all("run61", 8'h00, 8'h01, 8'h01, 2'b11, 1'b0);

    // INC is ignored in RUN.
    press(1'b0, 1'b1, 0);
    check_all("run_inc", 8'h00, 8'h01, 8'h01, 2'b11, 1'b0);

    // Preload 23:59:59 through set mode.
    press(1'b1, 1'b0, 0);
    check_all("enter_hh", 8'h00, 8'h01, 8'h01, 2'b00, 1'b1);
    press_n(1'b0, 1'b1, 23);
    check("hh_23", hh, 8'h23);
    press(1'b1, 1'b0, 0);
    press_n(1'b0, 1'b1, 58);
    check("mm_59", mm, 8'h59);
    press(1'b1, 1'b0, 0);
    check("blink_ss", {6'b000000, blink_sel}, 8'h02);
    press_n(1'b0, 1'b1, 58);
    press(1'b1, 1'b0, 0);
    check_all("preload", 8'h23, 8'h59, 8'h59, 2'b11, 1'b0);
    ticks(1);
    check_all("wrap_day", 8'h00, 8'h00, 8'h00, 2'b11, 1'b0);

    // Bounce shorter than the qualification window: no press.
    for (int k = 0; k < 10; k++) begin
      btn_mode_raw = ~btn_mode_raw;
      repeat (2) @(negedge clk);
    end
    btn_mode_raw = 1'b0;
    repeat (10) @(negedge clk);
    check_all("bounce", 8'h00, 8'h00, 8'h00, 2'b11, 1'b0);
    btn_mode_raw = 1'b1;
    repeat (10) @(negedge clk);
    check_all("held", 8'h00, 8'h00, 8'h00, 2'b00, 1'b1);
    btn_mode_raw = 1'b0;
    repeat (8) @(negedge clk);

    // SET_MM: 58 -> 59 -> 00 without carry; ticks ignored.
    press(1'b1, 1'b0, 0);
    press_n(1'b0, 1'b1, 58);
    check_all("mm_58", 8'h00, 8'h58, 8'h00, 2'b01, 1'b1);
    press(1'b0, 1'b1, 3);
    press(1'b0, 1'b1, 2);
    check_all("mm_wrap", 8'h00, 8'h00, 8'h00, 2'b01, 1'b1);

    // Reach SET_HH with hh=05, then coincident MODE+INC.
    press_n(1'b1, 1'b0, 3);
    check("back_hh", {6'b000000, blink_sel}, 8'h00);
    press_n(1'b0, 1'b1, 5);
    check("hh_05", hh, 8'h05);
    press(1'b1, 1'b1, 0);
    check_all("mode_wins", 8'h05, 8'h00, 8'h00, 2'b01, 1'b1);

    // SET_SS at 37, reset during an INC debounce.
    press(1'b1, 1'b0, 0);
    press_n(1'b0, 1'b1, 37);
    check_all("ss_37", 8'h05, 8'h00, 8'h37, 2'b10, 1'b1);
    btn_inc_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 8'h00, 8'h00, 2'b11, 1'b0);
    btn_inc_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_all("post_rst", 8'h00, 8'h00, 8'h00, 2'b11, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
